// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//   IF stage of the uDLX pipeline. Holds the PC, issues reads to a synchronous
//   instruction memory (1-cycle read latency) and registers each fetched word
//   into the IF/ID pipe register that feeds instruction_decode.
//
//   A decode stall can land while a read is still in flight. A 1-entry hold
//   buffer catches that word. A taken branch or jump squashes everything in
//   flight and restarts fetch at the target.
//
// Ports
//   clk                  clock, rising edge
//   rst                  asynchronous reset, active-high
//   stall_in             hazard stall from decode: hold IF/ID, do not fetch
//   branch_taken_in      redirect request from execute (wins over stall)
//   branch_target_in     redirect target address
//   instr_mem_addr_out   instruction-memory read address (= pc_reg)
//   instr_mem_rd_en_out  read strobe; data returns on instr_mem_data_in next cycle
//   instr_mem_data_in    instruction-memory read data
//   instruction_out      IF/ID instruction (NOP_INSTR when not valid)
//   new_pc_out           IF/ID PC of fetched instruction + PC_STEP
//   valid_out            IF/ID holds a real instruction
// ---------------------------------------------------------------------------
module instruction_fetch #(
    parameter int                           PC_WIDTH          = 20,
    parameter int                           INSTRUCTION_WIDTH = 32,
    parameter int                           PC_STEP           = 1,
    parameter int                           RESET_PC          = 0,
    parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSTR         = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall_in,
    input  logic                         branch_taken_in,
    input  logic [PC_WIDTH-1:0]          branch_target_in,
    output logic [PC_WIDTH-1:0]          instr_mem_addr_out,
    output logic                         instr_mem_rd_en_out,
    input  logic [INSTRUCTION_WIDTH-1:0] instr_mem_data_in,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_out,
    output logic [PC_WIDTH-1:0]          new_pc_out,
    output logic                         valid_out
);

    localparam logic [PC_WIDTH-1:0] STEP     = PC_WIDTH'(PC_STEP);
    localparam logic [PC_WIDTH-1:0] START_PC = PC_WIDTH'(RESET_PC);

    typedef enum logic [1:0] {
        MODE_RUN,
        MODE_STALL,
        MODE_REDIRECT
    } mode_t;

    mode_t                         mode;
    logic                          issue;

    logic [PC_WIDTH-1:0]           pc_reg;
    logic                          pending_reg;
    logic [PC_WIDTH-1:0]           pending_pc_reg;
    logic                          hold_valid_reg;
    logic [INSTRUCTION_WIDTH-1:0]  hold_instr_reg;
    logic [PC_WIDTH-1:0]           hold_pc_reg;
    logic [INSTRUCTION_WIDTH-1:0]  instr_reg;
    logic [PC_WIDTH-1:0]           new_pc_reg;
    logic                          valid_reg;

    // Redirect beats stall, and stall beats run.
    always_comb begin
        mode = MODE_RUN;
        if (branch_taken_in) begin
            mode = MODE_REDIRECT;
        end else if (stall_in) begin
            mode = MODE_STALL;
        end
    end

    // No fetch is issued while stalled. That is why the hold buffer needs only
    // one entry: at most one word can be in flight when a stall starts.
    assign issue               = !rst && !stall_in && !branch_taken_in;
    assign instr_mem_rd_en_out = issue;
    assign instr_mem_addr_out  = pc_reg;

    assign instruction_out = instr_reg;
    assign new_pc_out      = new_pc_reg;
    assign valid_out       = valid_reg;

    // PC and in-flight tracking. The PC wraps silently modulo 2^PC_WIDTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg         <= START_PC;
            pending_reg    <= 1'b0;
            pending_pc_reg <= '0;
        end else begin
            if (mode == MODE_REDIRECT) begin
                pc_reg <= branch_target_in;
            end else if (issue) begin
                pc_reg <= pc_reg + STEP;
            end
            pending_reg <= issue;
            if (issue) begin
                pending_pc_reg <= pc_reg;
            end
        end
    end

    // The hold buffer catches a word that returns while decode is stalled.
    // It drains on the first run cycle and is discarded on a redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid_reg <= 1'b0;
            hold_instr_reg <= '0;
            hold_pc_reg    <= '0;
        end else begin
            case (mode)
                MODE_REDIRECT: hold_valid_reg <= 1'b0;
                MODE_STALL: begin
                    if (pending_reg) begin
                        hold_instr_reg <= instr_mem_data_in;
                        hold_pc_reg    <= pending_pc_reg + STEP;
                        hold_valid_reg <= 1'b1;
                    end
                end
                default: hold_valid_reg <= 1'b0;
            endcase
        end
    end

    // IF/ID register. In a run cycle, hold and pending are never both set,
    // so the load-source order below cannot lose a word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_reg  <= NOP_INSTR;
            new_pc_reg <= '0;
            valid_reg  <= 1'b0;
        end else begin
            case (mode)
                MODE_REDIRECT: begin
                    instr_reg <= NOP_INSTR;
                    valid_reg <= 1'b0;
                end
                MODE_STALL: begin
                    // IF/ID is frozen while decode is stalled.
                end
                default: begin
                    if (hold_valid_reg) begin
                        instr_reg  <= hold_instr_reg;
                        new_pc_reg <= hold_pc_reg;
                        valid_reg  <= 1'b1;
                    end else if (pending_reg) begin
                        instr_reg  <= instr_mem_data_in;
                        new_pc_reg <= pending_pc_reg + STEP;
                        valid_reg  <= 1'b1;
                    end else begin
                        instr_reg  <= NOP_INSTR;
                        valid_reg  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
